// File: rtl/data_mem_port.sv
// data_mem_port: byte-serial data-memory access controller for the single-cycle datapath.
// Turns word/halfword/byte loads and stores from the control unit into handshaked byte
// beats (little-endian, lane 0 first), stalls the datapath while an access is in flight,
// and returns sign-extended load data. Misaligned or read+write requests are rejected.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   MemRead, MemWrite   00 none, 01 word, 10 halfword, 11 byte
//   addr, wdata         byte address and store data from the datapath
//   rdata               sign-extended load result, held until the next completed load
//   stall               datapath hold request (combinational)
//   done, err           one-cycle completion / rejection pulses
//   mem_req, mem_we     beat request and direction toward the byte memory
//   mem_addr, mem_wdata registered beat address and write byte
//   mem_rdata, mem_ack  read byte and beat-complete strobe from the memory
`timescale 1ns/1ps
module data_mem_port #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    MemRead,
  input  logic [1:0]    MemWrite,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

  state_e        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [1:0]    last_q, last_d;     // index of the final beat: 0 byte, 1 half, 3 word
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;     // address of the current beat
  logic [31:0]   wdata_q, wdata_d;   // store data, shifted down one byte per beat
  logic [31:0]   lbuf_q, lbuf_d;     // load bytes gathered so far
  logic [31:0]   rdata_q, rdata_d;

  logic          cmd;
  logic [1:0]    size_code;
  logic          misalign;
  logic          bad;
  logic [1:0]    last_new;
  logic [31:0]   lbuf_nx;
  logic [31:0]   load_ext;
  logic          unused_addr;

  assign unused_addr = ^addr[31:AW];

  // Request decode, meaningful only in StIdle.
  always_comb begin
    cmd       = (MemRead != 2'b00) || (MemWrite != 2'b00);
    size_code = (MemRead != 2'b00) ? MemRead : MemWrite;
    misalign  = ((size_code == 2'b01) && (addr[1:0] != 2'b00)) ||
                ((size_code == 2'b10) && addr[0]);
    bad       = ((MemRead != 2'b00) && (MemWrite != 2'b00)) || misalign;
    unique case (size_code)
      2'b01:   last_new = 2'd3;
      2'b10:   last_new = 2'd1;
      default: last_new = 2'd0;
    endcase
  end

  // Load buffer with the byte arriving this cycle merged into its lane, and the
  // sign-extended result derived from it so the final beat lands in rdata directly.
  always_comb begin
    lbuf_nx = lbuf_q;
    lbuf_nx[{beat_q, 3'b000} +: 8] = mem_rdata;
    unique case (last_q)
      2'd0:    load_ext = {{24{lbuf_nx[7]}}, lbuf_nx[7:0]};
      2'd1:    load_ext = {{16{lbuf_nx[15]}}, lbuf_nx[15:0]};
      default: load_ext = lbuf_nx;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lbuf_d  = lbuf_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    mem_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd) begin
          stall = 1'b1;
          if (bad) begin
            state_d = StErr;
          end else begin
            state_d = StAccess;
            beat_d  = 2'd0;
            last_d  = last_new;
            we_d    = (MemWrite != 2'b00);
            addr_d  = addr[AW-1:0];
            wdata_d = wdata;
            lbuf_d  = 32'h0;
          end
        end
      end
      StAccess: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          beat_d  = beat_q + 2'd1;
          addr_d  = addr_q + AW'(1);
          wdata_d = {8'h00, wdata_q[31:8]};
          if (!we_q) begin
            lbuf_d = lbuf_nx;
          end
          if (beat_q == last_q) begin
            state_d = StDone;
            if (!we_q) begin
              rdata_d = load_ext;
            end
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
      last_q  <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      lbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lbuf_q  <= lbuf_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q[7:0];

endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboard bench for data_mem_port: the driver computes each request's expected beats
// and completion from a byte-array memory model and queues them; a memory responder and a
// completion monitor pop and compare as the DUT presents beats and done/err pulses.
`timescale 1ns/1ps
module tb_data_mem_port;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    MemRead, MemWrite;
  logic [31:0]   addr, wdata, rdata;
  logic          stall, done, err, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  data_mem_port #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
    .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit is_err; logic [31:0] rdata;} exp_t;
  typedef struct {logic [15:0] a; bit we; logic [7:0] d;} beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];

  logic [7:0]  mem     [0:65535];   // memory as the DUT actually wrote it
  logic [7:0]  ref_mem [0:65535];   // memory as the model says it should be
  logic [31:0] last_load = 32'h0;
  int          wait_mode = 0;       // 0 zero-wait, 1 random 0..2 waits, 2 fixed 2 waits
  int          beats_acked = 0;
  bit          after_end = 1'b0;    // DUT sits in DONE/ERR right now
  int unsigned last_done_cyc = 0;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] b);
    mem[a]     = b;
    ref_mem[a] = b;
  endtask

  // Memory responder: chooses the wait count per beat and checks every beat it completes.
  initial begin
    beat_t b;
    bit    in_beat;
    int    wleft;
    in_beat = 1'b0;
    wleft   = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !reset) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          wleft   = (wait_mode == 0) ? 0 : (wait_mode == 2) ? 2 : int'($urandom_range(0, 2));
        end
        if (wleft > 0) begin
          wleft--;
          mem_ack = 1'b0;
        end else begin
          mem_ack = 1'b1;
          in_beat = 1'b0;
          beats_acked++;
          if (beat_q.size() == 0) begin
            chk("unexpected_beat", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            b = beat_q.pop_front();
            chk("beat_addr", 32'(mem_addr), 32'(b.a));
            chk("beat_we", 32'(mem_we), 32'(b.we));
            if (b.we) begin
              chk("beat_wdata", 32'(mem_wdata), 32'(b.d));
              mem[mem_addr] = mem_wdata;
            end else begin
              mem_rdata = mem[mem_addr];
            end
          end
        end
      end else begin
        mem_ack   = 1'b0;
        in_beat   = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (done || err)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", {30'h0, done, err}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("completion_err", 32'(err), 32'(e.is_err));
          chk("completion_done", 32'(done), 32'(!e.is_err));
          chk("completion_rdata", rdata, e.rdata);
        end
      end
    end
  end

  // Issue one request in an IDLE cycle, queue its expectations, wait for done/err.
  task automatic run_op(input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] a, input logic [31:0] d);
    logic [1:0]  sz;
    logic [15:0] ba;
    logic [31:0] v;
    int          nb, n, lat;
    bit          bad, got;
    if (after_end) begin
      @(posedge clk);
      #1;
    end
    sz  = (rd != 2'b00) ? rd : wr;
    nb  = (sz == 2'b01) ? 4 : (sz == 2'b10) ? 2 : 1;
    bad = ((rd != 2'b00) && (wr != 2'b00)) || ((sz == 2'b01) && (a[1:0] != 2'b00)) ||
          ((sz == 2'b10) && a[0]);
    if (bad) begin
      exp_q.push_back('{is_err: 1'b1, rdata: last_load});
      lat = 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) begin
        ba = a[15:0] + 16'(i);
        if (wr != 2'b00) begin
          ref_mem[ba] = d[8*i +: 8];
          beat_q.push_back('{a: ba, we: 1'b1, d: d[8*i +: 8]});
        end else begin
          v[8*i +: 8] = ref_mem[ba];
          beat_q.push_back('{a: ba, we: 1'b0, d: 8'h00});
        end
      end
      if (rd != 2'b00) begin
        if (nb == 1)      v = {{24{v[7]}}, v[7:0]};
        else if (nb == 2) v = {{16{v[15]}}, v[15:0]};
        last_load = v;
      end
      exp_q.push_back('{is_err: 1'b0, rdata: last_load});
      lat = (wait_mode == 2) ? 1 + 3 * nb : 1 + nb;
    end
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    #1;
    chk("stall_on_issue", 32'(stall), 32'h1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      MemRead  = 2'b00;
      MemWrite = 2'b00;
      addr     = $urandom;
      wdata    = $urandom;
      #1;
      if (done || err) got = 1'b1;
      else chk("stall_busy", 32'(stall), 32'h1);
    end
    if (!got) chk("completion_timeout", 32'(n), 32'(lat));
    chk("stall_at_end", 32'(stall), 32'h0);
    if (wait_mode != 1) chk("latency", 32'(n), 32'(lat));
    last_done_cyc = cyc;
    after_end     = 1'b1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
    if (k > 0) after_end = 1'b0;
  endtask

  initial begin
    int          n, diffs;
    int unsigned prev;
    logic [1:0]  rd, wr, sz;
    logic [31:0] a;
    reset    = 1'b1;
    MemRead  = 2'b00;
    MemWrite = 2'b00;
    addr     = 32'h0;
    wdata    = 32'h0;
    mem_ack  = 1'b0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) poke(16'(i), 8'($urandom));
    #2;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_flags", {27'h0, stall, done, err, mem_req, mem_we}, 32'h0);
    chk("reset_mem_bus", {8'h00, mem_addr, mem_wdata}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // LW, zero wait
    wait_mode = 0;
    poke(16'h10, 8'h11); poke(16'h11, 8'h22); poke(16'h12, 8'h33); poke(16'h13, 8'h44);
    run_op(2'b01, 2'b00, 32'h10, 32'h0);
    chk("lw_value", rdata, 32'h4433_2211);

    // LB / LH sign extension
    poke(16'h7, 8'h80);
    run_op(2'b11, 2'b00, 32'h7, 32'h0);
    chk("lb_sext", rdata, 32'hFFFF_FF80);
    poke(16'h6, 8'h34); poke(16'h7, 8'h12);
    run_op(2'b10, 2'b00, 32'h6, 32'h0);
    chk("lh_value", rdata, 32'h0000_1234);

    // SW with two wait cycles per beat
    wait_mode = 2;
    run_op(2'b00, 2'b01, 32'h20, 32'hDEAD_BEEF);
    chk("sw_rdata_kept", rdata, 32'h0000_1234);
    chk("sw_bytes", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, 32'hDEAD_BEEF);

    // Rejected requests
    wait_mode   = 0;
    beats_acked = 0;
    run_op(2'b10, 2'b00, 32'h3, 32'h0);
    run_op(2'b01, 2'b01, 32'h10, 32'h5555_5555);
    chk("err_no_beats", 32'(beats_acked), 32'h0);
    chk("err_rdata_kept", rdata, 32'h0000_1234);

    // Reset during beat 2 of a store
    @(posedge clk);
    #1;
    after_end   = 1'b0;
    beats_acked = 0;
    MemWrite = 2'b01;
    addr     = 32'h40;
    wdata    = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++)
      beat_q.push_back('{a: 16'h40 + 16'(i), we: 1'b1, d: 8'(32'hCAFE_F00D >> (8 * i))});
    n = 0;
    while (beats_acked < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      MemWrite = 2'b00;
    end
    chk("midop_two_beats", 32'(beats_acked), 32'h2);
    chk("midop_req_before", 32'(mem_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("midop_req", 32'(mem_req), 32'h0);
    chk("midop_stall", 32'(stall), 32'h0);
    chk("midop_rdata", rdata, 32'h0);
    beat_q.delete();
    ref_mem[16'h40] = 8'h0D;
    ref_mem[16'h41] = 8'hF0;
    last_load = 32'h0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op(2'b11, 2'b00, 32'h0, 32'h0);

    // Address wrap, then a back-to-back SB
    run_op(2'b01, 2'b00, 32'h0000_FFFC, 32'h0);
    prev = last_done_cyc;
    run_op(2'b00, 2'b11, 32'h50, 32'h0000_00A5);
    chk("b2b_gap", 32'(last_done_cyc - prev), 32'h3);

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      wait_mode = int'($urandom_range(0, 2));
      sz = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        rd = sz;
        wr = 2'($urandom_range(1, 3));
      end else if ($urandom_range(0, 1) == 0) begin
        rd = sz;
        wr = 2'b00;
      end else begin
        rd = 2'b00;
        wr = sz;
      end
      a = ($urandom_range(0, 3) == 0) ? 32'hFFF0 + $urandom_range(0, 15)
                                      : $urandom_range(0, 255);
      if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
      run_op(rd, wr, a, $urandom);
      idle(int'($urandom_range(0, 1)));
    end

    idle(2);
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("memory_image", 32'(diffs), 32'h0);
    chk("queues_drained", 32'(exp_q.size() + beat_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
